// File: rtl/local_bus_controller_pkg.sv
// Shared encodings for the local bus controller: FSM states, port sizes,
// DSACK codes and the byte-lane strobe helper.
package local_bus_controller_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SEL  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_EXT  = 3'd3;
  localparam logic [2:0] ST_ACK  = 3'd4;
  localparam logic [2:0] ST_BERR = 3'd5;

  localparam logic [1:0] PORT_32 = 2'd0;
  localparam logic [1:0] PORT_16 = 2'd1;
  localparam logic [1:0] PORT_8  = 2'd2;

  // DSACK1:DSACK0, active-low
  localparam logic [1:0] DSACK_32   = 2'b00;
  localparam logic [1:0] DSACK_16   = 2'b01;
  localparam logic [1:0] DSACK_8    = 2'b10;
  localparam logic [1:0] DSACK_NONE = 2'b11;

  function automatic logic [1:0] dsack_code(input logic [1:0] port);
    case (port)
      PORT_16: return DSACK_16;
      PORT_8:  return DSACK_8;
      default: return DSACK_32;
    endcase
  endfunction

  // Active-low byte strobes; bit 3 is D31:D24.
  function automatic logic [3:0] lane_strobes(input logic [1:0] siz, input logic [1:0] a);
    logic [3:0] pat;
    case (siz)
      2'b01:   pat = 4'b1000;
      2'b10:   pat = 4'b1100;
      2'b11:   pat = 4'b1110;
      default: pat = 4'b1111;
    endcase
    return ~(pat >> a);
  endfunction

endpackage

// File: rtl/local_bus_controller_sync.sv
// Two-flop synchroniser for asynchronous bus handshake inputs.
module bus_sync #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // first stage may go metastable; second stage feeds the logic
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/local_bus_controller.sv
// 68030 local bus controller: device decode, chip selects, byte lanes,
// wait states, DSACK sizing and VME forwarding with bus-error timeout.
//
// state | meaning
// IDLE  | no cycle, all outputs inactive
// SEL   | address latched, decode settles, wait counter loads
// WAIT  | local device wait states counting down
// EXT   | VME request out, waiting for ack / berr
// ACK   | DSACK driven until AS negates
// BERR  | bus error driven until AS negates
module local_bus_controller
  import local_bus_controller_pkg::*;
#(
  parameter int                 N_DEV    = 4,
  parameter logic [4*N_DEV-1:0] DEV_BASE = 16'h7210,
  parameter logic [4*N_DEV-1:0] DEV_MASK = 16'hFFFF,
  parameter logic [4*N_DEV-1:0] DEV_WAIT = 16'h4112,
  parameter logic [2*N_DEV-1:0] DEV_PORT = 8'h80,
  parameter int                 TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             cpu_as,
  input  logic             cpu_ds,
  input  logic [1:0]       cpu_siz,
  input  logic [1:0]       address,
  input  logic [3:0]       address_high,
  input  logic             n_address_top,
  input  logic             n_ext_ack,
  input  logic             n_ext_berr,
  output logic [N_DEV-1:0] n_dev_sel,
  output logic [3:0]       n_lane_ds,
  output logic [1:0]       n_dsack,
  output logic             n_berr,
  output logic             n_vme_a16,
  output logic             n_vme_a24,
  output logic             n_vme_a40
);

  localparam logic [11:0] TMO_LAST = 12'(TIMEOUT - 1);

  logic [3:0] sync_q;
  logic       as_s, ds_s, ack_s, berr_s;

  logic [2:0]  state, next;
  logic        idle_q;
  logic [3:0]  wait_cnt;
  logic [11:0] tmo_cnt;
  logic        tmo_hit;

  logic [3:0] lat_high;
  logic       lat_top;
  logic [1:0] lat_addr, lat_siz;

  logic             hit;
  logic [N_DEV-1:0] sel_vec;
  logic [1:0]       dev_port;
  logic [3:0]       dev_wait;
  logic             vme16, vme24, vme40;
  logic             busy;

  bus_sync #(.WIDTH(4), .RST_VAL(4'b1111)) u_sync (
    .clk     (clk),
    .n_reset (n_reset),
    .d       ({cpu_as, cpu_ds, n_ext_ack, n_ext_berr}),
    .q       (sync_q)
  );

  assign {as_s, ds_s, ack_s, berr_s} = sync_q;

  function automatic logic dev_match(input logic [3:0] a, input logic [3:0] base,
                                     input logic [3:0] mask);
    return (a & mask) == (base & mask);
  endfunction

  // decode latched address; descending scan so the lowest index wins
  always_comb begin
    hit      = 1'b0;
    sel_vec  = '0;
    dev_port = PORT_32;
    dev_wait = 4'd0;
    for (int i = N_DEV - 1; i >= 0; i--) begin
      if (dev_match(lat_high, DEV_BASE[4*i +: 4], DEV_MASK[4*i +: 4])) begin
        hit        = 1'b1;
        sel_vec    = '0;
        sel_vec[i] = 1'b1;
        dev_port   = DEV_PORT[2*i +: 2];
        dev_wait   = DEV_WAIT[4*i +: 4];
      end
    end
  end

  assign vme16   = !hit && !lat_top && (lat_high == 4'hF);
  assign vme24   = !hit && !lat_top && (lat_high != 4'hF);
  assign vme40   = !hit && lat_top;
  assign tmo_hit = (tmo_cnt >= TMO_LAST);

  // next state: berr beats ack, ack / zero wait beat timeout
  always_comb begin
    next = state;
    case (state)
      ST_IDLE: if (!as_s && idle_q) next = ST_SEL;
      ST_SEL: begin
        if (as_s)     next = ST_IDLE;
        else if (hit) next = ST_WAIT;
        else          next = ST_EXT;
      end
      ST_WAIT: begin
        if (as_s)                 next = ST_IDLE;
        else if (wait_cnt == 4'd0) next = ST_ACK;
        else if (tmo_hit)          next = ST_BERR;
      end
      ST_EXT: begin
        if (as_s)         next = ST_IDLE;
        else if (!berr_s) next = ST_BERR;
        else if (!ack_s)  next = ST_ACK;
        else if (tmo_hit) next = ST_BERR;
      end
      ST_ACK, ST_BERR: if (as_s) next = ST_IDLE;
      default: next = ST_IDLE;
    endcase
  end

  // state, idle-hold flag, counters and address latch
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state    <= ST_IDLE;
      idle_q   <= 1'b1;
      wait_cnt <= 4'd0;
      tmo_cnt  <= 12'd0;
      lat_high <= 4'd0;
      lat_top  <= 1'b1;
      lat_addr <= 2'd0;
      lat_siz  <= 2'd0;
    end else begin
      state  <= next;
      idle_q <= (state == ST_IDLE);
      if (state == ST_IDLE && next == ST_SEL) begin
        lat_high <= address_high;
        lat_top  <= n_address_top;
        lat_addr <= address;
        lat_siz  <= cpu_siz;
      end
      if (state == ST_SEL)
        wait_cnt <= dev_wait;
      else if (state == ST_WAIT && wait_cnt != 4'd0)
        wait_cnt <= wait_cnt - 4'd1;
      else if (state == ST_IDLE)
        wait_cnt <= 4'd0;
      if (state == ST_WAIT || state == ST_EXT)
        tmo_cnt <= tmo_cnt + 12'd1;
      else if (state == ST_IDLE)
        tmo_cnt <= 12'd0;
    end
  end

  assign busy = (state != ST_IDLE);

  // registered outputs: selects follow current state, acks follow next state
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      n_dev_sel <= '1;
      n_lane_ds <= 4'hF;
      n_dsack   <= DSACK_NONE;
      n_berr    <= 1'b1;
      n_vme_a16 <= 1'b1;
      n_vme_a24 <= 1'b1;
      n_vme_a40 <= 1'b1;
    end else begin
      n_dev_sel <= (busy && hit) ? ~sel_vec : '1;
      n_lane_ds <= (busy && hit && dev_port == PORT_32 && !ds_s) ?
                   lane_strobes(lat_siz, lat_addr) : 4'hF;
      n_dsack   <= (next == ST_ACK) ? (hit ? dsack_code(dev_port) : DSACK_32) : DSACK_NONE;
      n_berr    <= (next != ST_BERR);
      n_vme_a16 <= !(busy && vme16);
      n_vme_a24 <= !(busy && vme24);
      n_vme_a40 <= !(busy && vme40);
    end
  end

endmodule
